// File: rtl/axi_burst_arbiter_pkg.sv
// Shared cache/AXI definitions: FSM state encodings, burst length limit and
// the cache-line offset width used for the read-after-writeback hazard check.
package axi_burst_arbiter_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam logic [7:0]  AXI_MAX_LEN = 8'd7;
    localparam int unsigned LINE_OFS_W  = 5;

endpackage

// File: rtl/axi_beat_counter.sv
// Burst beat counter: loads a burst length, counts beats down and flags a
// beat whose last marker disagrees with the remaining count.
module axi_beat_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    input  logic       last,
    output logic       len_err
);

    logic [7:0] count;
    logic       zero;

    assign zero = (count == '0);

    // Saturates at zero so an overlong burst keeps flagging until its last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - 8'd1;
        end
    end

    assign len_err = dec && (last != zero);

endmodule

// File: rtl/axi_burst_arbiter.sv
// Arbitrates i-cache and d-cache AXI read bursts onto one memory port and
// passes d-cache writebacks through, blocking d-reads that hit the line in flight.
module axi_burst_arbiter
    import axi_burst_arbiter_pkg::*;
#(
    parameter bit         RR      = 1'b1,
    parameter logic [7:0] MAX_LEN = AXI_MAX_LEN
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] i_araddr,
    input  logic [7:0]  i_arlen,
    input  logic [2:0]  i_arsize,
    input  logic        i_arvalid,
    output logic        i_arready,
    output logic [31:0] i_rdata,
    output logic        i_rlast,
    output logic        i_rvalid,
    input  logic        i_rready,

    input  logic [31:0] d_araddr,
    input  logic [7:0]  d_arlen,
    input  logic [2:0]  d_arsize,
    input  logic        d_arvalid,
    output logic        d_arready,
    output logic [31:0] d_rdata,
    output logic        d_rlast,
    output logic        d_rvalid,
    input  logic        d_rready,

    input  logic [31:0] d_awaddr,
    input  logic [7:0]  d_awlen,
    input  logic [2:0]  d_awsize,
    input  logic        d_awvalid,
    output logic        d_awready,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    input  logic        d_wlast,
    input  logic        d_wvalid,
    output logic        d_wready,
    output logic        d_bvalid,
    input  logic        d_bready,

    output logic [31:0] m_araddr,
    output logic [7:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic        m_rlast,
    input  logic        m_rvalid,
    output logic        m_rready,

    output logic [31:0] m_awaddr,
    output logic [7:0]  m_awlen,
    output logic [2:0]  m_awsize,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wlast,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic        m_bvalid,
    output logic        m_bready,

    output logic        err_len
);

    rd_state_t   r_state, r_next;
    wr_state_t   w_state, w_next;
    owner_t      owner, last_grant, grant_side;
    logic        grant_en, d_hazard, d_req;
    logic        owner_rready;
    logic        ar_hs, r_hs, aw_take, aw_hs, w_hs, b_hs;
    logic        r_len_err, w_len_err, err_set;
    logic [31:0] aw_addr_q;
    logic [7:0]  aw_len_q;
    logic [2:0]  aw_size_q;
    logic [7:0]  owner_arlen;

    assign owner_arlen  = (owner == OWN_D) ? d_arlen : i_arlen;
    assign m_araddr     = (owner == OWN_D) ? d_araddr : i_araddr;
    assign m_arlen      = owner_arlen;
    assign m_arsize     = (owner == OWN_D) ? d_arsize : i_arsize;
    assign owner_rready = (owner == OWN_D) ? d_rready : i_rready;

    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;
    assign i_rlast  = m_rlast;
    assign d_rlast  = m_rlast;

    assign m_awaddr = aw_addr_q;
    assign m_awlen  = aw_len_q;
    assign m_awsize = aw_size_q;
    assign m_wdata  = d_wdata;
    assign m_wstrb  = d_wstrb;
    assign m_wlast  = d_wlast;

    assign ar_hs   = (r_state == R_ADDR) && m_arready;
    assign r_hs    = (r_state == R_DATA) && m_rvalid && owner_rready;
    assign aw_take = (w_state == W_IDLE) && d_awvalid;
    assign aw_hs   = (w_state == W_ADDR) && m_awready;
    assign w_hs    = (w_state == W_DATA) && d_wvalid && m_wready;
    assign b_hs    = (w_state == W_RESP) && m_bvalid && d_bready;

    always_comb begin
        d_hazard = (w_state != W_IDLE) &&
                   (d_araddr[31:LINE_OFS_W] == aw_addr_q[31:LINE_OFS_W]);
        d_req    = d_arvalid && !d_hazard;
        grant_en = (r_state == R_IDLE) && (i_arvalid || d_req);
        if (i_arvalid && d_req) begin
            if (RR && (last_grant == OWN_D)) grant_side = OWN_I;
            else                             grant_side = OWN_D;
        end else if (d_req) begin
            grant_side = OWN_D;
        end else begin
            grant_side = OWN_I;
        end
    end

    axi_beat_counter u_r_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (ar_hs),
        .load_val (owner_arlen),
        .dec      (r_hs),
        .last     (m_rlast),
        .len_err  (r_len_err)
    );

    axi_beat_counter u_w_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (aw_hs),
        .load_val (aw_len_q),
        .dec      (w_hs),
        .last     (d_wlast),
        .len_err  (w_len_err)
    );

    assign err_set = r_len_err || w_len_err ||
                     (ar_hs && (owner_arlen > MAX_LEN)) ||
                     (aw_take && (d_awlen > MAX_LEN));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
        end else begin
            r_state <= r_next;
            w_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= OWN_I;
            last_grant <= OWN_I;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            err_len    <= 1'b0;
        end else begin
            if (grant_en) begin
                owner      <= grant_side;
                last_grant <= grant_side;
            end
            if (aw_take) begin
                aw_addr_q <= d_awaddr;
                aw_len_q  <= d_awlen;
                aw_size_q <= d_awsize;
            end
            if (err_set) err_len <= 1'b1;
        end
    end

    // Handshake outputs are forced low while rst is high, even mid-burst.
    always_comb begin
        r_next    = r_state;
        m_arvalid = 1'b0;
        i_arready = 1'b0;
        d_arready = 1'b0;
        i_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        m_rready  = 1'b0;
        if (!rst) begin
            unique case (r_state)
                R_IDLE: begin
                    if (grant_en) r_next = R_ADDR;
                end
                R_ADDR: begin
                    m_arvalid = 1'b1;
                    if (owner == OWN_D) d_arready = m_arready;
                    else                i_arready = m_arready;
                    if (m_arready) r_next = R_DATA;
                end
                R_DATA: begin
                    m_rready = owner_rready;
                    if (owner == OWN_D) d_rvalid = m_rvalid;
                    else                i_rvalid = m_rvalid;
                    if (r_hs && m_rlast) r_next = R_IDLE;
                end
                default: r_next = R_IDLE;
            endcase
        end
    end

    always_comb begin
        w_next    = w_state;
        m_awvalid = 1'b0;
        d_awready = 1'b0;
        m_wvalid  = 1'b0;
        d_wready  = 1'b0;
        d_bvalid  = 1'b0;
        m_bready  = 1'b0;
        if (!rst) begin
            unique case (w_state)
                W_IDLE: begin
                    if (aw_take) w_next = W_ADDR;
                end
                W_ADDR: begin
                    m_awvalid = 1'b1;
                    d_awready = m_awready;
                    if (m_awready) w_next = W_DATA;
                end
                W_DATA: begin
                    m_wvalid = d_wvalid;
                    d_wready = m_wready;
                    if (w_hs && d_wlast) w_next = W_RESP;
                end
                W_RESP: begin
                    d_bvalid = m_bvalid;
                    m_bready = d_bready;
                    if (b_hs) w_next = W_IDLE;
                end
                default: w_next = W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_arbiter.sv
// Directed bench for axi_burst_arbiter: arbitration, routing, hazard, length errors, reset.
module tb_axi_burst_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] i_araddr, d_araddr, d_awaddr, d_wdata, m_rdata;
    logic [7:0]  i_arlen, d_arlen, d_awlen;
    logic [2:0]  i_arsize, d_arsize, d_awsize;
    logic        i_arvalid, d_arvalid, d_awvalid, d_wvalid, d_wlast, d_bready;
    logic        i_rready, d_rready;
    logic [3:0]  d_wstrb;
    logic        m_arready, m_rlast, m_rvalid, m_awready, m_wready, m_bvalid;

    logic        i_arready, i_rlast, i_rvalid, d_arready, d_rlast, d_rvalid;
    logic [31:0] i_rdata, d_rdata, m_araddr, m_awaddr, m_wdata;
    logic        d_awready, d_wready, d_bvalid;
    logic [7:0]  m_arlen, m_awlen;
    logic [2:0]  m_arsize, m_awsize;
    logic        m_arvalid, m_rready, m_awvalid, m_wlast, m_wvalid, m_bready, err_len;
    logic [3:0]  m_wstrb;

    logic        i0_arvalid, d0_arvalid, m0_arready, m0_rvalid, m0_rlast;
    logic        z_i_arready, z_i_rlast, z_i_rvalid, z_d_arready, z_d_rlast, z_d_rvalid;
    logic [31:0] z_i_rdata, z_d_rdata, z_m_araddr, z_m_awaddr, z_m_wdata;
    logic        z_d_awready, z_d_wready, z_d_bvalid;
    logic [7:0]  z_m_arlen, z_m_awlen;
    logic [2:0]  z_m_arsize, z_m_awsize;
    logic        z_m_arvalid, z_m_rready, z_m_awvalid, z_m_wlast, z_m_wvalid, z_m_bready, z_err_len;
    logic [3:0]  z_m_wstrb;

    int total = 0;
    int bad   = 0;

    axi_burst_arbiter #(.RR(1'b1), .MAX_LEN(8'd7)) dut (
        .clk(clk), .rst(rst),
        .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arvalid(i_arvalid),
        .i_arready(i_arready), .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid),
        .i_rready(i_rready),
        .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize), .d_arvalid(d_arvalid),
        .d_arready(d_arready), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid),
        .d_rready(d_rready),
        .d_awaddr(d_awaddr), .d_awlen(d_awlen), .d_awsize(d_awsize), .d_awvalid(d_awvalid),
        .d_awready(d_awready), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wlast(d_wlast),
        .d_wvalid(d_wvalid), .d_wready(d_wready), .d_bvalid(d_bvalid), .d_bready(d_bready),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arvalid(m_arvalid),
        .m_arready(m_arready), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awvalid(m_awvalid),
        .m_awready(m_awready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .err_len(err_len)
    );

    axi_burst_arbiter #(.RR(1'b0), .MAX_LEN(8'd7)) dut0 (
        .clk(clk), .rst(rst),
        .i_araddr(32'h4000_0000), .i_arlen(8'd0), .i_arsize(3'd2), .i_arvalid(i0_arvalid),
        .i_arready(z_i_arready), .i_rdata(z_i_rdata), .i_rlast(z_i_rlast), .i_rvalid(z_i_rvalid),
        .i_rready(1'b1),
        .d_araddr(32'h5000_0000), .d_arlen(8'd0), .d_arsize(3'd2), .d_arvalid(d0_arvalid),
        .d_arready(z_d_arready), .d_rdata(z_d_rdata), .d_rlast(z_d_rlast), .d_rvalid(z_d_rvalid),
        .d_rready(1'b1),
        .d_awaddr(32'h0), .d_awlen(8'd0), .d_awsize(3'd0), .d_awvalid(1'b0),
        .d_awready(z_d_awready), .d_wdata(32'h0), .d_wstrb(4'h0), .d_wlast(1'b0),
        .d_wvalid(1'b0), .d_wready(z_d_wready), .d_bvalid(z_d_bvalid), .d_bready(1'b0),
        .m_araddr(z_m_araddr), .m_arlen(z_m_arlen), .m_arsize(z_m_arsize), .m_arvalid(z_m_arvalid),
        .m_arready(m0_arready), .m_rdata(32'h0), .m_rlast(m0_rlast), .m_rvalid(m0_rvalid),
        .m_rready(z_m_rready),
        .m_awaddr(z_m_awaddr), .m_awlen(z_m_awlen), .m_awsize(z_m_awsize), .m_awvalid(z_m_awvalid),
        .m_awready(1'b0), .m_wdata(z_m_wdata), .m_wstrb(z_m_wstrb), .m_wlast(z_m_wlast),
        .m_wvalid(z_m_wvalid), .m_wready(1'b0), .m_bvalid(1'b0), .m_bready(z_m_bready),
        .err_len(z_err_len)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic read_beats(input int n, input bit to_d, input logic [31:0] base, input bit with_last);
        for (int k = 0; k < n; k++) begin
            m_rvalid = 1'b1;
            m_rdata  = base + k;
            m_rlast  = with_last && (k == n - 1);
            #1;
            chk("rbeat_owner_valid", to_d ? d_rvalid : i_rvalid, 1);
            chk("rbeat_other_valid", to_d ? i_rvalid : d_rvalid, 0);
            chk("rbeat_data", to_d ? d_rdata : i_rdata, base + k);
            step();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
    endtask

    initial begin
        int  grants;
        bit  found;

        rst = 1'b1;
        i_araddr = '0; i_arlen = '0; i_arsize = 3'd2; i_arvalid = 1'b0; i_rready = 1'b1;
        d_araddr = '0; d_arlen = '0; d_arsize = 3'd2; d_arvalid = 1'b0; d_rready = 1'b1;
        d_awaddr = '0; d_awlen = '0; d_awsize = 3'd2; d_awvalid = 1'b0;
        d_wdata = '0; d_wstrb = 4'hF; d_wlast = 1'b0; d_wvalid = 1'b0; d_bready = 1'b0;
        m_arready = 1'b0; m_rdata = '0; m_rlast = 1'b0; m_rvalid = 1'b1;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
        i0_arvalid = 1'b0; d0_arvalid = 1'b0; m0_arready = 1'b0; m0_rvalid = 1'b0; m0_rlast = 1'b0;

        // reset state
        step(); step(); #1;
        chk("rst_m_arvalid", m_arvalid, 0);
        chk("rst_i_arready", i_arready, 0);
        chk("rst_d_arready", d_arready, 0);
        chk("rst_i_rvalid", i_rvalid, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        chk("rst_m_rready", m_rready, 0);
        chk("rst_m_awvalid", m_awvalid, 0);
        chk("rst_d_bvalid", d_bvalid, 0);
        chk("rst_err_len", err_len, 0);
        m_rvalid = 1'b0;
        rst = 1'b0;
        step();

        // simultaneous I/D after reset: D first, then I
        i_araddr = 32'h2000_0000; i_arlen = 8'd7; i_arvalid = 1'b1;
        d_araddr = 32'h3000_0000; d_arlen = 8'd7; d_arvalid = 1'b1;
        #1 chk("idle_no_comb_arvalid", m_arvalid, 0);
        step(); #1;
        chk("rr_first_arvalid", m_arvalid, 1);
        chk("rr_first_is_d", m_araddr, 32'h3000_0000);
        chk("rr_first_arlen", m_arlen, 7);
        chk("rr_first_d_arready_wait", d_arready, 0);
        m_arready = 1'b1;
        #1;
        chk("rr_first_d_arready", d_arready, 1);
        chk("rr_first_i_arready", i_arready, 0);
        step();
        m_arready = 1'b0; d_arvalid = 1'b0;
        #1 chk("ar_dropped_in_data", m_arvalid, 0);
        read_beats(8, 1'b1, 32'hA000_0000, 1'b1);
        d_arvalid = 1'b1;
        #1;
        chk("no_zero_gap_grant", m_arvalid, 0);
        chk("burst8_no_err", err_len, 0);
        step(); #1;
        chk("rr_second_arvalid", m_arvalid, 1);
        chk("rr_second_is_i", m_araddr, 32'h2000_0000);
        m_arready = 1'b1;
        #1;
        chk("rr_second_i_arready", i_arready, 1);
        chk("rr_second_d_arready", d_arready, 0);
        step();
        m_arready = 1'b0; i_arvalid = 1'b0; d_arvalid = 1'b0;
        read_beats(8, 1'b0, 32'hB000_0000, 1'b1);

        // writeback hazard holds a same-line D read until B handshake
        d_awaddr = 32'h1000_0040; d_awlen = 8'd1; d_awvalid = 1'b1;
        step(); #1;
        chk("aw_valid", m_awvalid, 1);
        chk("aw_addr", m_awaddr, 32'h1000_0040);
        d_araddr = 32'h1000_0044; d_arlen = 8'd0; d_arvalid = 1'b1; m_awready = 1'b1;
        #1 chk("aw_ready", d_awready, 1);
        step();
        d_awvalid = 1'b0; m_awready = 1'b0;
        #1 chk("hazard_hold_a", m_arvalid, 0);
        d_wvalid = 1'b1; d_wdata = 32'hD0D0_0001; d_wlast = 1'b0; m_wready = 1'b1;
        #1;
        chk("w_valid", m_wvalid, 1);
        chk("w_data", m_wdata, 32'hD0D0_0001);
        chk("w_ready", d_wready, 1);
        step();
        d_wdata = 32'hD0D0_0002; d_wlast = 1'b1;
        #1;
        chk("hazard_hold_b", m_arvalid, 0);
        chk("w_last", m_wlast, 1);
        step();
        d_wvalid = 1'b0; d_wlast = 1'b0; m_wready = 1'b0;
        #1 chk("hazard_hold_resp", m_arvalid, 0);
        m_bvalid = 1'b1; d_bready = 1'b1;
        #1;
        chk("b_valid", d_bvalid, 1);
        chk("b_ready", m_bready, 1);
        step();
        m_bvalid = 1'b0;
        #1;
        chk("hazard_grant_delay", m_arvalid, 0);
        chk("b_done", d_bvalid, 0);
        step(); #1;
        chk("hazard_released", m_arvalid, 1);
        chk("hazard_read_addr", m_araddr, 32'h1000_0044);
        m_arready = 1'b1;
        step();
        m_arready = 1'b0; d_arvalid = 1'b0;
        read_beats(1, 1'b1, 32'hC000_0000, 1'b1);
        chk("wb_no_err", err_len, 0);

        // I read concurrent with D write
        i_araddr = 32'h2000_0100; i_arlen = 8'd1; i_arvalid = 1'b1;
        d_awaddr = 32'h1000_0080; d_awlen = 8'd1; d_awvalid = 1'b1;
        step(); #1;
        chk("conc_arvalid", m_arvalid, 1);
        chk("conc_awvalid", m_awvalid, 1);
        chk("conc_araddr", m_araddr, 32'h2000_0100);
        m_arready = 1'b1; m_awready = 1'b1;
        step();
        i_arvalid = 1'b0; d_awvalid = 1'b0; m_arready = 1'b0; m_awready = 1'b0;
        d_wvalid = 1'b1; m_wready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_rvalid = 1'b1; m_rlast = (k == 1); m_rdata = 32'hE100_0000 + k;
            d_wlast = (k == 1); d_wdata = 32'hE200_0000 + k;
            #1;
            chk("conc_i_rvalid", i_rvalid, 1);
            chk("conc_d_rvalid", d_rvalid, 0);
            chk("conc_wvalid", m_wvalid, 1);
            chk("conc_wdata", m_wdata, 32'hE200_0000 + k);
            step();
        end
        m_rvalid = 1'b0; m_rlast = 1'b0; d_wvalid = 1'b0; d_wlast = 1'b0; m_wready = 1'b0;
        m_bvalid = 1'b1; d_bready = 1'b1;
        #1;
        chk("conc_bvalid", d_bvalid, 1);
        chk("conc_idle_i_rvalid", i_rvalid, 0);
        step();
        m_bvalid = 1'b0;
        #1;
        chk("conc_w_idle", m_bready, 0);
        chk("conc_no_err", err_len, 0);

        // early rlast: arlen=7, rlast on beat 6
        d_araddr = 32'h3000_0200; d_arlen = 8'd7; d_arvalid = 1'b1;
        step();
        m_arready = 1'b1;
        step();
        d_arvalid = 1'b0; m_arready = 1'b0;
        read_beats(6, 1'b1, 32'hF000_0000, 1'b1);
        #1;
        chk("early_last_err", err_len, 1);
        chk("early_last_idle", m_arvalid, 0);
        m_rvalid = 1'b1;
        #1 chk("early_last_no_route", d_rvalid, 0);
        m_rvalid = 1'b0;
        step(); step(); step(); #1;
        chk("err_sticky", err_len, 1);
        rst = 1'b1;
        step(); #1;
        chk("err_cleared_by_rst", err_len, 0);
        rst = 1'b0;

        // reset during beat 3 of an I burst
        i_araddr = 32'h2000_0300; i_arlen = 8'd7; i_arvalid = 1'b1;
        step();
        m_arready = 1'b1;
        step();
        i_arvalid = 1'b0; m_arready = 1'b0;
        read_beats(2, 1'b0, 32'h1234_0000, 1'b0);
        m_rvalid = 1'b1; m_rlast = 1'b0; rst = 1'b1;
        step(); #1;
        chk("midrst_i_rvalid", i_rvalid, 0);
        chk("midrst_d_rvalid", d_rvalid, 0);
        chk("midrst_m_rready", m_rready, 0);
        chk("midrst_m_arvalid", m_arvalid, 0);
        rst = 1'b0;
        #1 chk("midrst_idle_no_route", i_rvalid, 0);
        m_rvalid = 1'b0;
        d_araddr = 32'h3000_0400; d_arlen = 8'd1; d_arvalid = 1'b1;
        step(); #1;
        chk("fresh_d_araddr", m_araddr, 32'h3000_0400);
        m_arready = 1'b1;
        step();
        d_arvalid = 1'b0; m_arready = 1'b0;
        read_beats(2, 1'b1, 32'h5555_0000, 1'b1);
        #1 chk("fresh_d_no_err", err_len, 0);

        // arlen above MAX_LEN flags an error but the burst still runs
        i_araddr = 32'h2000_0500; i_arlen = 8'd9; i_arvalid = 1'b1;
        step();
        m_arready = 1'b1;
        step();
        i_arvalid = 1'b0; m_arready = 1'b0;
        read_beats(10, 1'b0, 32'h6666_0000, 1'b1);
        #1;
        chk("len_over_max_err", err_len, 1);
        chk("len_over_max_idle", m_arvalid, 0);

        // fixed priority: I never granted while D keeps requesting
        i0_arvalid = 1'b1; d0_arvalid = 1'b1; m0_arready = 1'b1; m0_rvalid = 1'b1; m0_rlast = 1'b1;
        grants = 0;
        for (int c = 0; c < 12; c++) begin
            step(); #1;
            chk("fp_i_arready", z_i_arready, 0);
            chk("fp_i_rvalid", z_i_rvalid, 0);
            if (z_m_arvalid) begin
                grants++;
                chk("fp_grant_is_d", z_m_araddr, 32'h5000_0000);
            end
        end
        chk("fp_grant_count", grants, 4);
        d0_arvalid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 6 && !found; c++) begin
            step(); #1;
            if (z_m_arvalid) found = 1'b1;
        end
        chk("fp_i_eventually", found, 1);
        chk("fp_i_addr", z_m_araddr, 32'h4000_0000);
        chk("fp_i_arready", z_i_arready, 1);
        i0_arvalid = 1'b0; m0_arready = 1'b0; m0_rvalid = 1'b0; m0_rlast = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_burst_arbiter.md
AXI_BURST_ARBITER -- requirements
Module: axi_burst_arbiter

Interface
REQ-001 SHALL have parameter RR, default 1, meaning read arbitration policy: 1 = round-robin, 0 = fixed priority to the d-side.
REQ-002 SHALL have parameter MAX_LEN, default 8'd7, meaning the largest legal arlen/awlen, equal to 8 beats.
REQ-003 clk  in  1  sole clock; all logic on posedge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 i_araddr/i_arlen/i_arsize/i_arvalid  in  32/8/3/1  i-cache read request; i_arready out 1.
REQ-006 i_rdata/i_rlast/i_rvalid  out  32/1/1  i-cache read response; i_rready in 1.
REQ-007 d_araddr/d_arlen/d_arsize/d_arvalid  in  32/8/3/1  d-cache read request; d_arready out 1.
REQ-008 d_rdata/d_rlast/d_rvalid  out  32/1/1  d-cache read response; d_rready in 1.
REQ-009 d_awaddr/d_awlen/d_awsize/d_awvalid, d_wdata/d_wstrb/d_wlast/d_wvalid, d_bready  in  32/8/3/1, 32/4/1/1, 1  d-cache write channels; d_awready/d_wready/d_bvalid out 1.
REQ-010 m_ar*/m_aw*/m_w*/m_rready/m_bready  out  same widths  shared bus toward the memory side; m_arready/m_r*/m_awready/m_wready/m_bvalid in.
REQ-011 err_len  out  1  sticky protocol-error flag.

Function
REQ-012 Read FSM SHALL have states R_IDLE, R_ADDR, R_DATA; exactly one grant owner (I or D) is held in R_ADDR/R_DATA.
REQ-013 In R_IDLE with any arvalid, SHALL register a grant next cycle and enter R_ADDR; no combinational path from arvalid to m_arvalid in R_IDLE.
REQ-014 Arbitration with both valid: RR=1 grants the side not granted last (after reset, D first); RR=0 always grants D.
REQ-015 In R_ADDR, m_ar* SHALL equal the owner's ar*, and only the owner's arready mirrors m_arready; the other side's arready = 0.
REQ-016 On m_arvalid&m_arready SHALL latch arlen into a beat counter, enter R_DATA, and deassert m_arvalid next cycle.
REQ-017 In R_DATA, m_r* SHALL route only to the owner; the non-owner's rvalid = 0; m_rready = owner rready.
REQ-018 Each R handshake SHALL decrement the counter; the beat with m_rlast returns to R_IDLE and releases the grant in the same edge.
REQ-019 If m_rlast arrives with counter != 0, or the counter reaches 0 without m_rlast, SHALL set err_len and still return to R_IDLE on m_rlast.
REQ-020 Write FSM SHALL have states W_IDLE, W_ADDR, W_DATA, W_RESP, D-side only, with 1-cycle registered entry into W_ADDR.
REQ-021 In W_DATA, SHALL count W beats; must see d_wlast exactly on beat awlen+1, otherwise err_len is set; exit on the wlast handshake to W_RESP.
REQ-022 In W_RESP, SHALL return to W_IDLE on m_bvalid&m_bready.
REQ-023 A D read SHALL NOT be granted while the write FSM is outside W_IDLE and d_araddr[31:5] equals the latched awaddr[31:5] (read-after-writeback hazard); I reads are unaffected.
REQ-024 arlen or awlen > MAX_LEN SHALL set err_len; the transfer still proceeds.
REQ-025 Read and write FSMs SHALL run concurrently and independently, except for REQ-023.
REQ-026 On simultaneous R_IDLE entry and a new arvalid, the new grant SHALL take effect one cycle later (no zero-gap grant).

Reset
REQ-027 rst SHALL force R_IDLE, W_IDLE, last-grant = I (so D wins first), counters = 0, err_len = 0.
REQ-028 During rst all valid/ready outputs SHALL be 0; rst mid-burst abandons the burst with no completion signalled to either side.

Structure
REQ-029 State encodings, MAX_LEN and the hazard line-offset width (5) SHALL live in the shared cache/AXI package.
REQ-030 One sub-module, axi_beat_counter (load/decrement/zero/last-check), SHALL be instantiated twice, once for R and once for W.

Verification
REQ-031 I and D arvalid same cycle, RR=1, post-reset -> D granted, 8 beats to D only; next simultaneous request -> I granted.
REQ-032 RR=0, I continuously valid, D valid every burst -> I never granted while D is valid.
REQ-033 D writeback to 0x1000_0040 in W_DATA plus D read 0x1000_0044 -> read held until bvalid&bready; then granted.
REQ-034 arlen=7 and m_rlast on beat 6 -> err_len=1, FSM back to R_IDLE, err_len sticky until rst.
REQ-035 rst asserted during beat 3 of an I burst -> next cycle all valids 0, states idle; a fresh D request completes normally.
REQ-036 I read burst concurrent with D write burst -> both complete, with no cross-routing of rvalid to D.
